// File: rtl/quant_block_pkg.sv
// rtl/quant_block_pkg.sv - shared constants, FSM states and zigzag scan for the 4x4 quantizer
package quant_block_pkg;

  localparam int QFIX      = 17;
  localparam int MAX_LEVEL = 2047;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Zigzag position n -> raster lane j
  function automatic logic [3:0] zigzag(input logic [3:0] n);
    logic [3:0] j;
    case (n)
      4'd0:    j = 4'd0;
      4'd1:    j = 4'd1;
      4'd2:    j = 4'd4;
      4'd3:    j = 4'd8;
      4'd4:    j = 4'd5;
      4'd5:    j = 4'd2;
      4'd6:    j = 4'd3;
      4'd7:    j = 4'd6;
      4'd8:    j = 4'd9;
      4'd9:    j = 4'd12;
      4'd10:   j = 4'd13;
      4'd11:   j = 4'd10;
      4'd12:   j = 4'd7;
      4'd13:   j = 4'd11;
      4'd14:   j = 4'd14;
      default: j = 4'd15;
    endcase
    return j;
  endfunction

endpackage

// File: rtl/quant_block_lane.sv
// rtl/quant_block_lane.sv - single-coefficient quantizer pipeline
// Stage 1 registers sign/magnitude/threshold/product; stage 2 clamps, restores sign and dequantizes.
module quant_block_lane
  import quant_block_pkg::*;
#(
  parameter int I_WIDTH  = 12,
  parameter int L_WIDTH  = 12,
  parameter int DQ_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [3:0]                 in_n,
  input  logic [3:0]                 in_j,
  input  logic signed [I_WIDTH-1:0]  in_coef,
  input  logic [15:0]                in_q,
  input  logic [15:0]                in_iq,
  input  logic [31:0]                in_bias,
  input  logic [31:0]                in_zthresh,
  input  logic [15:0]                in_sharpen,
  output logic                       out_valid,
  output logic [3:0]                 out_n,
  output logic [3:0]                 out_j,
  output logic signed [L_WIDTH-1:0]  out_level,
  output logic [DQ_WIDTH-1:0]        out_dq
);

  localparam int PW = L_WIDTH + 17;

  logic [I_WIDTH:0] abs_c;
  logic [16:0]      mag_c;
  logic             pass_c;
  logic [32:0]      p_c;

  // One extra bit so that the most negative input still has a positive magnitude
  assign abs_c  = in_coef[I_WIDTH-1] ? (~{1'b1, in_coef} + 1'b1) : {1'b0, in_coef};
  assign mag_c  = 17'(abs_c) + 17'(in_sharpen);
  assign pass_c = 32'(mag_c) > in_zthresh;
  assign p_c    = 33'(mag_c) * 33'(in_iq) + 33'(in_bias);

  logic        s1_valid;
  logic [3:0]  s1_n;
  logic [3:0]  s1_j;
  logic        s1_sign;
  logic        s1_pass;
  logic [32:0] s1_p;
  logic [15:0] s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_n     <= '0;
      s1_j     <= '0;
      s1_sign  <= 1'b0;
      s1_pass  <= 1'b0;
      s1_p     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_n     <= in_n;
      s1_j     <= in_j;
      s1_sign  <= in_coef[I_WIDTH-1];
      s1_pass  <= pass_c;
      s1_p     <= p_c;
      s1_q     <= in_q;
    end
  end

  logic [15:0]              quo;
  logic [L_WIDTH-2:0]       clamp_mag;
  logic [L_WIDTH-1:0]       lv_abs;
  logic signed [PW-1:0]     lv_ext;
  logic signed [PW-1:0]     q_ext;
  logic signed [PW-1:0]     prod;

  assign quo       = s1_p[32:QFIX];
  assign clamp_mag = (32'(quo) > MAX_LEVEL) ? (L_WIDTH-1)'(MAX_LEVEL) : quo[L_WIDTH-2:0];
  assign lv_abs    = s1_pass ? {1'b0, clamp_mag} : '0;
  assign out_level = s1_sign ? -lv_abs : lv_abs;
  assign lv_ext    = PW'(out_level);
  assign q_ext     = PW'({1'b0, s1_q});
  assign prod      = lv_ext * q_ext;
  assign out_dq    = prod[DQ_WIDTH-1:0];
  assign out_valid = s1_valid;
  assign out_n     = s1_n;
  assign out_j     = s1_j;

endmodule

// File: rtl/quant_block.sv
// rtl/quant_block.sv - VP8 4x4 coefficient quantizer: FSM, step counter, coefficient latch, lane muxes
module quant_block
  import quant_block_pkg::*;
#(
  parameter int I_WIDTH  = 12,
  parameter int L_WIDTH  = 12,
  parameter int DQ_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [16*I_WIDTH-1:0]    coef,
  input  logic [16*16-1:0]         q,
  input  logic [16*16-1:0]         iq,
  input  logic [16*32-1:0]         bias,
  input  logic [16*32-1:0]         zthresh,
  input  logic [16*16-1:0]         sharpen,
  output logic [16*L_WIDTH-1:0]    level,
  output logic [16*DQ_WIDTH-1:0]   dq,
  output logic                     nz,
  output logic [3:0]               last,
  output logic                     busy,
  output logic                     done
);

  state_t state_q, state_d;
  logic [3:0] step_q;
  logic [16*I_WIDTH-1:0] coef_q;
  logic accept;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end
      end
      ST_RUN:   if (step_q == 4'd15) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q <= '0;
        coef_q <= coef;
      end else if (state_q == ST_RUN) begin
        step_q <= step_q + 4'd1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  logic [3:0] lane_j;
  assign lane_j = zigzag(step_q);

  logic                      o_valid;
  logic [3:0]                o_n;
  logic [3:0]                o_j;
  logic signed [L_WIDTH-1:0] o_level;
  logic [DQ_WIDTH-1:0]       o_dq;

  quant_block_lane #(
    .I_WIDTH (I_WIDTH),
    .L_WIDTH (L_WIDTH),
    .DQ_WIDTH(DQ_WIDTH)
  ) u_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == ST_RUN),
    .in_n      (step_q),
    .in_j      (lane_j),
    .in_coef   (coef_q[lane_j*I_WIDTH +: I_WIDTH]),
    .in_q      (q[lane_j*16 +: 16]),
    .in_iq     (iq[lane_j*16 +: 16]),
    .in_bias   (bias[lane_j*32 +: 32]),
    .in_zthresh(zthresh[lane_j*32 +: 32]),
    .in_sharpen(sharpen[lane_j*16 +: 16]),
    .out_valid (o_valid),
    .out_n     (o_n),
    .out_j     (o_j),
    .out_level (o_level),
    .out_dq    (o_dq)
  );

  // Steps arrive in increasing n, so the last write with a non-zero level is the highest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      dq    <= '0;
      nz    <= 1'b0;
      last  <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state_q == ST_FLUSH);
      if (accept) begin
        level <= '0;
        dq    <= '0;
        nz    <= 1'b0;
        last  <= '0;
      end else if (o_valid) begin
        level[o_n*L_WIDTH +: L_WIDTH] <= o_level;
        dq[o_j*DQ_WIDTH +: DQ_WIDTH]  <= o_dq;
        if (o_level != '0) begin
          nz   <= 1'b1;
          last <= o_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_quant_block.sv
// tb/tb_quant_block.sv - directed self-checking bench for quant_block
module tb_quant_block;

  localparam int IW = 12;
  localparam int LW = 12;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [16*IW-1:0]     coef = '0;
  logic [16*16-1:0]     q = '0;
  logic [16*16-1:0]     iq = '0;
  logic [16*32-1:0]     bias = '0;
  logic [16*32-1:0]     zthresh = '0;
  logic [16*16-1:0]     sharpen = '0;
  logic [16*LW-1:0]     level;
  logic [16*DW-1:0]     dq;
  logic                 nz;
  logic [3:0]           last;
  logic                 busy;
  logic                 done;

  quant_block #(.I_WIDTH(IW), .L_WIDTH(LW), .DQ_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef(coef), .q(q), .iq(iq),
    .bias(bias), .zthresh(zthresh), .sharpen(sharpen), .level(level), .dq(dq),
    .nz(nz), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int c[16];
  int exp_level[16];
  int exp_dq[16];

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_params(input int qv, input int iqv, input logic [31:0] bv, input logic [31:0] zv);
    for (int j = 0; j < 16; j++) begin
      q[j*16 +: 16]       = 16'(qv);
      iq[j*16 +: 16]      = 16'(iqv);
      bias[j*32 +: 32]    = bv;
      zthresh[j*32 +: 32] = zv;
      sharpen[j*16 +: 16] = '0;
    end
  endtask

  task automatic clear_vectors();
    for (int j = 0; j < 16; j++) begin
      c[j] = 0;
      exp_level[j] = 0;
      exp_dq[j] = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic launch();
    for (int j = 0; j < 16; j++) coef[j*IW +: IW] = IW'(c[j]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; 17 edges = done in cycle k+18
  task automatic wait_done(input string tag, input int exp_edges);
    int lat;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, exp_edges);
    check({tag, " busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic check_block(input string tag, input int exp_nz, input int exp_last);
    for (int n = 0; n < 16; n++)
      check($sformatf("%s level[%0d]", tag, n), $signed(level[n*LW +: LW]), exp_level[n]);
    for (int j = 0; j < 16; j++)
      check($sformatf("%s dq[%0d]", tag, j), $signed(dq[j*DW +: DW]), exp_dq[j]);
    check({tag, " nz"}, 32'(nz), exp_nz);
    check({tag, " last"}, 32'(last), exp_last);
  endtask

  initial begin
    int seen;
    set_params(8, 16384, 32'd0, 32'd0);
    clear_vectors();
    repeat (2) @(negedge clk);
    check("reset level", 32'(level != '0), 0);
    check("reset dq", 32'(dq != '0), 0);
    check("reset nz", 32'(nz), 0);
    check("reset last", 32'(last), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    rst_n = 1'b1;

    // 1: all zero
    @(negedge clk);
    launch();
    check("t1 busy", 32'(busy), 1);
    wait_done("t1", 17);
    check_block("t1", 0, 0);

    // 2: coef[0]=100 -> 100*16384>>17 = 12, dq = 96
    clear_vectors();
    c[0] = 100; exp_level[0] = 12; exp_dq[0] = 96;
    @(negedge clk);
    launch();
    wait_done("t2", 17);
    check_block("t2", 1, 0);

    // 3: raster lane 5 is zigzag position 4
    clear_vectors();
    c[5] = -100; exp_level[4] = -12; exp_dq[5] = -96;
    @(negedge clk);
    launch();
    wait_done("t3", 17);
    check_block("t3", 1, 4);

    // 4: clamp, dq truncation, strict dead-zone
    set_params(8, 65535, 32'hFFFF_FFFF, 32'd0);
    q[15*16 +: 16] = 16'd40;
    zthresh[1*32 +: 32] = 32'd100;
    zthresh[2*32 +: 32] = 32'd100;
    clear_vectors();
    c[15] = 2047; exp_level[15] = 2047; exp_dq[15] = 16344;
    c[1]  = 100;
    c[2]  = 101;  exp_level[5] = 2047;  exp_dq[2] = 16376;
    @(negedge clk);
    launch();
    wait_done("t4", 17);
    check_block("t4", 1, 15);

    // 5: reset mid-block
    set_params(8, 16384, 32'd0, 32'd0);
    clear_vectors();
    c[0] = 100;
    @(negedge clk);
    launch();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 level", 32'(level != '0), 0);
    check("t5 dq", 32'(dq != '0), 0);
    check("t5 nz", 32'(nz), 0);
    check("t5 busy", 32'(busy), 0);
    check("t5 done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("t5 no_done", seen, 0);
    exp_level[0] = 12; exp_dq[0] = 96;
    @(negedge clk);
    launch();
    wait_done("t5b", 17);
    check_block("t5b", 1, 0);

    // 6: start while busy ignored; start coincident with done accepted
    clear_vectors();
    c[0] = 100; exp_level[0] = 12; exp_dq[0] = 96;
    @(negedge clk);
    launch();
    c[0] = -100;
    for (int j = 0; j < 16; j++) coef[j*IW +: IW] = IW'(c[j]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("t6a", 16);
    check_block("t6a", 1, 0);
    clear_vectors();
    c[5] = -100; exp_level[4] = -12; exp_dq[5] = -96;
    launch();
    wait_done("t6b", 17);
    check_block("t6b", 1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
